// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
package seg7_pkg;

   localparam int unsigned DEF_N_DIGITS = 8;
   localparam int unsigned MAX_DIGITS   = 16;
   localparam int unsigned SHADOW_MAX_W = 4 * MAX_DIGITS;

   // Segment bit positions within a_to_g (active-low).
   localparam int unsigned SEG_A = 6;
   localparam int unsigned SEG_B = 5;
   localparam int unsigned SEG_C = 4;
   localparam int unsigned SEG_D = 3;
   localparam int unsigned SEG_E = 2;
   localparam int unsigned SEG_F = 1;
   localparam int unsigned SEG_G = 0;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Nibble idx of a (zero-extended) shadow value.
   function automatic logic [3:0] nib_sel(input logic [SHADOW_MAX_W-1:0] shadow,
                                          input int unsigned idx);
      logic [SHADOW_MAX_W-1:0] sh;
      sh = shadow >> (idx * 4);
      return sh[3:0];
   endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Write-side valid/ready channel of the scan driver.
interface seg7_scan_driver_if
   import seg7_pkg::*;
#(
   parameter int unsigned N_DIGITS = DEF_N_DIGITS
);
   logic [4*N_DIGITS-1:0] wr_data;
   logic                  wr_valid;
   logic                  wr_ready;

   modport master (output wr_data, output wr_valid, input  wr_ready);
   modport slave  (input  wr_data, input  wr_valid, output wr_ready);
endinterface

// File: rtl/seg7_scan_driver_hex7seg.sv
// Hex nibble to active-low 7-segment decoder; bit6 = a, bit0 = g.
module hex7seg (
   input  logic [3:0] x,
   output logic [6:0] a_to_g
);
   always_comb begin
      a_to_g = 7'b1111111;
      case (x)
         4'h0: a_to_g = 7'b0000001;
         4'h1: a_to_g = 7'b1001111;
         4'h2: a_to_g = 7'b0010010;
         4'h3: a_to_g = 7'b0000110;
         4'h4: a_to_g = 7'b1001100;
         4'h5: a_to_g = 7'b0100100;
         4'h6: a_to_g = 7'b0100000;
         4'h7: a_to_g = 7'b0001111;
         4'h8: a_to_g = 7'b0000000;
         4'h9: a_to_g = 7'b0000100;
         4'hA: a_to_g = 7'b0001000;
         4'hB: a_to_g = 7'b1100000;
         4'hC: a_to_g = 7'b0110001;
         4'hD: a_to_g = 7'b1000010;
         4'hE: a_to_g = 7'b0110000;
         4'hF: a_to_g = 7'b0111000;
         default: a_to_g = 7'b1111111;
      endcase
   end
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment scan driver with tear-free,
// frame-aligned value updates over a valid/ready write channel.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned N_DIGITS     = DEF_N_DIGITS,
   parameter int unsigned REFRESH_DIV  = 100000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   seg7_scan_driver_if.slave   wr,
   input  logic [N_DIGITS-1:0] digit_en,
   input  logic [N_DIGITS-1:0] dp_i,
   input  logic                lz_en,
   output logic [N_DIGITS-1:0] an,
   output logic [6:0]          a_to_g,
   output logic                dp,
   output logic                frame_done
);
   localparam int unsigned TICK_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned IDX_W  = $clog2(N_DIGITS);
   localparam int unsigned DATA_W = 4 * N_DIGITS;

   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   pending_q, pending_d;
   logic [DATA_W-1:0]   shadow_q, shadow_d;
   logic                pend_full_q, pend_full_d;
   logic [N_DIGITS-1:0] an_q, an_d;
   logic [6:0]          seg_q, seg_d;
   logic                dp_q, dp_d;
   logic                frame_done_q, frame_done_d;

   logic       last_tick_c, last_idx_c, boundary_c, upper_zero_c, blank_c;
   logic [3:0] nib_c;
   logic [6:0] seg_c;

   assign wr.wr_ready = ~pend_full_q;

   hex7seg u_hex7seg (
      .x      (nib_c),
      .a_to_g (seg_c)
   );

   always_comb begin
      tick_d       = tick_q + TICK_W'(1);
      idx_d        = idx_q;
      pending_d    = pending_q;
      shadow_d     = shadow_q;
      pend_full_d  = pend_full_q;

      last_tick_c  = (tick_q == TICK_W'(REFRESH_DIV - 1));
      last_idx_c   = (idx_q == IDX_W'(N_DIGITS - 1));
      boundary_c   = last_tick_c && last_idx_c;

      if (last_tick_c) begin
         tick_d = '0;
         idx_d  = last_idx_c ? '0 : idx_q + IDX_W'(1);
      end

      // Promotion and acceptance are exclusive: ready is low whenever pending is full.
      if (boundary_c && pend_full_q) begin
         shadow_d    = pending_q;
         pend_full_d = 1'b0;
      end else if (wr.wr_valid && !pend_full_q) begin
         pending_d   = wr.wr_data;
         pend_full_d = 1'b1;
      end

      nib_c        = nib_sel(SHADOW_MAX_W'(shadow_q), 32'(idx_q));
      upper_zero_c = ((shadow_q >> {idx_q, 2'b00}) == '0);
      blank_c      = (tick_q < TICK_W'(BLANK_CYCLES))
                     || !digit_en[idx_q]
                     || (lz_en && (idx_q != '0) && upper_zero_c);

      an_d         = blank_c ? '1 : ~(N_DIGITS'(1) << idx_q);
      seg_d        = blank_c ? SEG_BLANK : seg_c;
      dp_d         = blank_c ? 1'b1 : ~dp_i[idx_q];
      frame_done_d = boundary_c;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tick_q       <= '0;
         idx_q        <= '0;
         pending_q    <= '0;
         shadow_q     <= '0;
         pend_full_q  <= 1'b0;
         an_q         <= '1;
         seg_q        <= SEG_BLANK;
         dp_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         tick_q       <= tick_d;
         idx_q        <= idx_d;
         pending_q    <= pending_d;
         shadow_q     <= shadow_d;
         pend_full_q  <= pend_full_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         dp_q         <= dp_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign an         = an_q;
   assign a_to_g     = seg_q;
   assign dp         = dp_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a cycle-count based reference model.
module tb_seg7_scan_driver;
   import seg7_pkg::*;

   localparam int unsigned ND = 8;
   localparam int unsigned RD = 4;
   localparam int unsigned BC = 1;
   localparam int unsigned FRAME = RD * ND;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] digit_en, dp_i, an;
   logic       lz_en;
   logic [6:0] a_to_g;
   logic       dp, frame_done;

   always #5 clk = ~clk;

   seg7_scan_driver_if #(.N_DIGITS(ND)) wr_if ();

   seg7_scan_driver #(
      .N_DIGITS     (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .wr         (wr_if),
      .digit_en   (digit_en),
      .dp_i       (dp_i),
      .lz_en      (lz_en),
      .an         (an),
      .a_to_g     (a_to_g),
      .dp         (dp),
      .frame_done (frame_done)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Model state: elapsed cycles since reset plus the two buffered values.
   int unsigned m_cyc;
   logic [31:0] m_shadow, m_pending;
   bit          m_pend_full;
   bit          have_exp = 0;
   logic [7:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp, e_fd;

   logic [7:0]  c_den = 8'hFF, c_dp = 8'h00;
   logic        c_lz = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Lit segments listed active-high as abcdefg, then inverted for the common-anode pins.
   function automatic logic [6:0] seg_of(input logic [3:0] n);
      logic [6:0] lit;
      case (n)
         4'h0: lit = 7'b1111110;  4'h1: lit = 7'b0110000;
         4'h2: lit = 7'b1101101;  4'h3: lit = 7'b1111001;
         4'h4: lit = 7'b0110011;  4'h5: lit = 7'b1011011;
         4'h6: lit = 7'b1011111;  4'h7: lit = 7'b1110000;
         4'h8: lit = 7'b1111111;  4'h9: lit = 7'b1111011;
         4'hA: lit = 7'b1110111;  4'hB: lit = 7'b0011111;
         4'hC: lit = 7'b1001110;  4'hD: lit = 7'b0111101;
         4'hE: lit = 7'b1001111;  default: lit = 7'b1000111;
      endcase
      return ~lit;
   endfunction

   task automatic step(input logic r, input logic v, input logic [31:0] d, output bit accepted);
      int unsigned tick, idx;
      bit          boundary, blank;
      logic [31:0] upper;
      @(negedge clk);
      if (have_exp) begin
         check("an", 32'(an), 32'(e_an));
         check("a_to_g", 32'(a_to_g), 32'(e_seg));
         check("dp", 32'(dp), 32'(e_dp));
         check("frame_done", 32'(frame_done), 32'(e_fd));
         check("wr_ready", 32'(wr_if.wr_ready), 32'(!m_pend_full));
      end
      rst_n          = r;
      wr_if.wr_valid = v;
      wr_if.wr_data  = d;
      digit_en       = c_den;
      dp_i           = c_dp;
      lz_en          = c_lz;
      accepted       = 0;
      if (!r) begin
         e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
         m_cyc = 0; m_shadow = 0; m_pend_full = 0;
      end else begin
         tick     = m_cyc % RD;
         idx      = (m_cyc / RD) % ND;
         boundary = (m_cyc % FRAME) == FRAME - 1;
         upper    = m_shadow >> (4 * idx);
         blank    = (tick < BC) || !c_den[idx] || (c_lz && idx != 0 && upper == 0);
         e_an     = blank ? 8'hFF : (8'hFF ^ (8'd1 << idx));
         e_seg    = blank ? 7'h7F : seg_of(upper[3:0]);
         e_dp     = blank ? 1'b1 : ~c_dp[idx];
         e_fd     = boundary;
         if (boundary && m_pend_full) begin
            m_shadow    = m_pending;
            m_pend_full = 0;
         end else if (v && !m_pend_full) begin
            m_pending   = d;
            m_pend_full = 1;
            accepted    = 1;
         end
         m_cyc++;
      end
      have_exp = 1;
   endtask

   task automatic idle(input int n);
      bit a;
      repeat (n) step(1'b1, 1'b0, $urandom, a);
   endtask

   task automatic write(input logic [31:0] d);
      bit a;
      int k = 0;
      do begin
         step(1'b1, 1'b1, d, a);
         k++;
      end while (!a && k < 200);
      check("write_accept", 32'(a), 32'd1);
   endtask

   initial begin
      bit a;
      int k;
      logic [31:0] rd;
      rst_n = 1'b0; wr_if.wr_valid = 1'b0; wr_if.wr_data = '0;
      digit_en = 8'hFF; dp_i = 8'h00; lz_en = 1'b0;

      repeat (3) step(1'b0, 1'b0, 32'h0, a);

      write(32'h0000_00A5);
      idle(2 * FRAME);
      c_lz = 1'b1;
      idle(FRAME);
      write(32'h0000_0000);
      idle(FRAME + 8);
      c_lz = 1'b0;

      write(32'h1234_5678);
      write(32'h9ABC_DEF0);
      idle(2 * FRAME + 8);

      c_den = 8'h0F; c_dp = 8'h08;
      idle(FRAME + 8);
      c_den = 8'hFF; c_dp = 8'h00;

      // Reset at digit 5 while a value is still pending.
      k = 0;
      while ((m_cyc % FRAME) != 0 && k < 100) begin idle(1); k++; end
      write(32'h5555_5555);
      k = 0;
      while (((m_cyc / RD) % ND) != 5 && k < 100) begin idle(1); k++; end
      check("pend_full_at_rst", 32'(wr_if.wr_ready), 32'd0);
      step(1'b0, 1'b0, 32'h0, a);
      idle(FRAME + 8);

      for (int i = 0; i < 2000; i++) begin
         if (i % 50 == 0) begin
            c_den = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            c_dp  = 8'($urandom);
            c_lz  = 1'($urandom);
         end
         rd = $urandom >> (4 * $urandom_range(0, 8));
         step(($urandom_range(0, 499) != 0), ($urandom_range(0, 2) == 0), rd, a);
      end
      idle(1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
